// File: rtl/apb_spim_lite.sv
// APB-attached single-lane SPI master (mode 0, MSB first) with 4-deep TX/RX byte FIFOs
// and level event outputs for RX-available and TX-done.
`timescale 1ns/1ps
module apb_spim_lite #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PSEL,
  input  logic        PENABLE,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        spi_clk_o,
  output logic        spi_csn_o,
  output logic        spi_sdo_o,
  input  logic        spi_sdi_i,
  output logic [1:0]  events_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d, clkdiv_q;
  logic        sck_q, sck_d, csn_q, csn_d, sdo_q, sdo_d;
  logic [7:0]  txsh_q, txsh_d, rxsh_q, rxsh_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic        enable_q, rx_ie_q, tx_ie_q, rx_ovf_q, rx_ovf_d;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

  logic       access, apb_wr, apb_rd, busy, tick;
  logic [2:0] idx;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push, tx_pop, rx_push, rx_push_ok, rx_pop;
  logic       unused_apb;

  assign access = PSEL & PENABLE;
  assign apb_wr = access & PWRITE;
  assign apb_rd = access & ~PWRITE;
  assign idx    = PADDR[4:2];
  assign unused_apb = ^{PADDR[11:5], PADDR[1:0], PWDATA[31:10]};

  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);

  // A full TX FIFO still accepts a write when the engine pops in the same cycle.
  assign tx_push    = apb_wr & (idx == 3'd3) & (~tx_full | tx_pop);
  assign rx_pop     = apb_rd & (idx == 3'd4) & ~rx_empty;
  assign rx_push_ok = rx_push & (~rx_full | rx_pop);

  assign busy = (state_q != StIdle);
  assign tick = (div_q >= clkdiv_q);

  assign PREADY    = 1'b1;
  assign spi_clk_o = sck_q;
  assign spi_csn_o = csn_q;
  assign spi_sdo_o = sdo_q;
  assign events_o  = {tx_ie_q & tx_empty & ~busy, rx_ie_q & ~rx_empty};

  always_comb begin
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (apb_rd) begin
      case (idx)
        3'd0: PRDATA = {24'b0, rx_ovf_q, 3'(rx_cnt_q), 3'(tx_cnt_q), busy};
        3'd1: PRDATA = {22'b0, tx_ie_q, rx_ie_q, 7'b0, enable_q};
        3'd2: PRDATA = {24'b0, clkdiv_q};
        3'd4: begin
          PRDATA  = rx_empty ? 32'b0 : {24'b0, rx_mem[rx_rptr_q]};
          PSLVERR = rx_empty;
        end
        default: PRDATA = '0;
      endcase
    end else if (apb_wr && idx == 3'd3 && !tx_push) begin
      PSLVERR = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    sck_d      = sck_q;
    csn_d      = csn_q;
    sdo_d      = sdo_q;
    txsh_d     = txsh_q;
    rxsh_d     = rxsh_q;
    tick_cnt_d = tick_cnt_q;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    if (state_q != StIdle) div_d = tick ? 8'd0 : div_q + 8'd1;
    case (state_q)
      StIdle: begin
        div_d = 8'd0;
        if (enable_q && !tx_empty) begin
          tx_pop  = 1'b1;
          txsh_d  = tx_mem[tx_rptr_q];
          sdo_d   = tx_mem[tx_rptr_q][7];
          csn_d   = 1'b0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (tick) begin
          state_d    = StShift;
          tick_cnt_d = 4'd0;
        end
      end
      StShift: begin
        if (tick) begin
          sck_d      = ~sck_q;
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (!sck_q) begin
            rxsh_d = {rxsh_q[6:0], spi_sdi_i};
          end else begin
            txsh_d = {txsh_q[6:0], 1'b0};
            sdo_d  = txsh_q[6];
          end
          if (tick_cnt_q == 4'd15) begin
            rx_push = 1'b1;
            // Chain the next byte without releasing CS.
            if (enable_q && !tx_empty) begin
              tx_pop = 1'b1;
              txsh_d = tx_mem[tx_rptr_q];
              sdo_d  = tx_mem[tx_rptr_q][7];
            end else begin
              state_d = StHold;
            end
          end
        end
      end
      StHold: begin
        if (tick) begin
          csn_d   = 1'b1;
          sdo_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + CW'(1);
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);
    rx_cnt_d = rx_cnt_q;
    if (rx_push_ok && !rx_pop) rx_cnt_d = rx_cnt_q + CW'(1);
    else if (!rx_push_ok && rx_pop) rx_cnt_d = rx_cnt_q - CW'(1);
    rx_ovf_d = rx_ovf_q;
    if (apb_wr && idx == 3'd1 && PWDATA[1]) rx_ovf_d = 1'b0;
    if (rx_push && !rx_push_ok) rx_ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= PWDATA[7:0];
    if (rx_push_ok) rx_mem[rx_wptr_q] <= rxsh_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      sck_q      <= 1'b0;
      csn_q      <= 1'b1;
      sdo_q      <= 1'b0;
      txsh_q     <= '0;
      rxsh_q     <= '0;
      tick_cnt_q <= '0;
      enable_q   <= 1'b0;
      rx_ie_q    <= 1'b0;
      tx_ie_q    <= 1'b0;
      rx_ovf_q   <= 1'b0;
      clkdiv_q   <= '0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sck_q      <= sck_d;
      csn_q      <= csn_d;
      sdo_q      <= sdo_d;
      txsh_q     <= txsh_d;
      rxsh_q     <= rxsh_d;
      tick_cnt_q <= tick_cnt_d;
      rx_ovf_q   <= rx_ovf_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      if (apb_wr && idx == 3'd1) begin
        enable_q <= PWDATA[0];
        rx_ie_q  <= PWDATA[8];
        tx_ie_q  <= PWDATA[9];
      end
      if (apb_wr && idx == 3'd2) clkdiv_q <= PWDATA[7:0];
      if (tx_push) tx_wptr_q <= tx_wptr_q + AW'(1);
      if (tx_pop) tx_rptr_q <= tx_rptr_q + AW'(1);
      if (rx_push_ok) rx_wptr_q <= rx_wptr_q + AW'(1);
      if (rx_pop) rx_rptr_q <= rx_rptr_q + AW'(1);
    end
  end

endmodule
